// File: rtl/acq_scheduler.sv
// Acquisition sequencer: walks a small slot table, driving the AZ mux, the precharge switch
// and the ADC reset/valid handshake, with a per-sample measurement timeout.
module acq_scheduler #(
  parameter int N_SLOTS = 4,
  parameter int CNT_W   = 24,
  localparam int SLOT_W = $clog2(N_SLOTS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              continuous_i,
  input  logic [SLOT_W:0]   n_slots_i,
  input  logic              cfg_we_i,
  input  logic [SLOT_W-1:0] cfg_addr_i,
  input  logic [5:0]        cfg_data_i,
  input  logic [CNT_W-1:0]  p_clk_count_precharge_i,
  input  logic [CNT_W-1:0]  timeout_i,
  input  logic              adc_measure_valid_i,
  output logic              adc_reset_no,
  output logic [3:0]        azmux_o,
  output logic [1:0]        sw_pc_ctl_o,
  output logic              busy_o,
  output logic              sample_valid_o,
  output logic [SLOT_W-1:0] sample_slot_o,
  output logic [15:0]       sample_count_o,
  output logic [2:0]        status_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_PC_BOOT, S_AZMUX, S_PC_SIG, S_MEASURE, S_NEXT
  } state_t;

  localparam logic [SLOT_W:0]   ONE_N = 1;
  localparam logic [SLOT_W-1:0] ONE_S = 1;
  localparam logic [CNT_W-1:0]  ONE_C = 1;
  localparam logic [SLOT_W:0]   MAX_N = (SLOT_W+1)'(N_SLOTS);

  state_t            state, next_state;
  logic [5:0]        slot_table [N_SLOTS];
  logic [CNT_W-1:0]  cnt;
  logic [SLOT_W-1:0] slot, slot_next;
  logic [SLOT_W:0]   n_active;
  logic [3:0]        cur_az;
  logic [1:0]        cur_pc;
  logic              stop_seen, running, timeout_err, sample_seen;
  logic              cnt_zero, last_slot;

  assign cnt_zero = (cnt == '0);
  assign busy_o   = running;
  assign status_o = {timeout_err, running, sample_seen};

  // Slot count of 0 runs one slot; anything above the table size runs the whole table.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    n_active = n_slots_i;
    if (n_slots_i == '0)
      n_active = ONE_N;
    else if (n_slots_i > MAX_N)
      n_active = MAX_N;
  end

  assign last_slot = ({1'b0, slot} == (n_active - ONE_N));
  assign slot_next = last_slot ? '0 : slot + ONE_S;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start_i && !stop_i) next_state = S_PC_BOOT;
      S_PC_BOOT: if (cnt_zero) next_state = S_AZMUX;
      S_AZMUX:   if (cnt_zero) next_state = S_PC_SIG;
      S_PC_SIG:  if (cnt_zero) next_state = S_MEASURE;
      S_MEASURE: begin
        // A valid arriving on the last timeout cycle still counts as a sample.
        if (adc_measure_valid_i) next_state = S_NEXT;
        else if (cnt_zero)       next_state = S_IDLE;
      end
      S_NEXT: begin
        if (stop_seen || (last_slot && !continuous_i)) next_state = S_IDLE;
        else                                           next_state = S_PC_BOOT;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the slot table is a register array cleared by reset, so it cannot map onto RAM.
      for (int i = 0; i < N_SLOTS; i++) slot_table[i] <= '0;
      cnt            <= '0;
      slot           <= '0;
      cur_az         <= '0;
      cur_pc         <= '0;
      stop_seen      <= 1'b0;
      running        <= 1'b0;
      timeout_err    <= 1'b0;
      sample_seen    <= 1'b0;
      adc_reset_no   <= 1'b0;
      azmux_o        <= '0;
      sw_pc_ctl_o    <= '0;
      sample_valid_o <= 1'b0;
      sample_slot_o  <= '0;
      sample_count_o <= '0;
    end else begin
      sample_valid_o <= 1'b0;
      if (cfg_we_i && !running) slot_table[cfg_addr_i] <= cfg_data_i;
      if (state != S_IDLE && stop_i) stop_seen <= 1'b1;

      // One down-counter serves both the phase dwell and the measurement timeout.
      if (next_state != state)
        cnt <= (next_state == S_MEASURE) ? timeout_i : p_clk_count_precharge_i;
      else if (!cnt_zero)
        cnt <= cnt - ONE_C;

      case (state)
        S_IDLE: begin
          if (next_state == S_PC_BOOT) begin
            sample_count_o   <= '0;
            timeout_err      <= 1'b0;
            running          <= 1'b1;
            stop_seen        <= 1'b0;
            slot             <= '0;
            {cur_az, cur_pc} <= slot_table[0];
            sw_pc_ctl_o      <= 2'b00;
          end
        end
        S_PC_BOOT: if (cnt_zero) azmux_o <= cur_az;
        S_AZMUX:   if (cnt_zero) sw_pc_ctl_o <= cur_pc;
        S_PC_SIG:  if (cnt_zero) adc_reset_no <= 1'b1;
        S_MEASURE: begin
          if (adc_measure_valid_i) begin
            adc_reset_no   <= 1'b0;
            sample_valid_o <= 1'b1;
            sample_slot_o  <= slot;
            sample_count_o <= sample_count_o + 16'd1;
            sample_seen    <= 1'b1;
          end else if (cnt_zero) begin
            adc_reset_no <= 1'b0;
            timeout_err  <= 1'b1;
            running      <= 1'b0;
          end
        end
        S_NEXT: begin
          if (next_state == S_IDLE) begin
            running <= 1'b0;
          end else begin
            slot             <= slot_next;
            {cur_az, cur_pc} <= slot_table[slot_next];
            sw_pc_ctl_o      <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_scheduler.sv
// Self-checking bench for acq_scheduler: directed runs, a behavioural ADC, and a
// scoreboard of expected samples checked by an independent monitor.
module tb_acq_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i, stop_i, continuous_i;
  logic [2:0]  n_slots_i;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [5:0]  cfg_data_i;
  logic [23:0] p_clk_count_precharge_i, timeout_i;
  logic        adc_measure_valid_i;
  logic        adc_reset_no;
  logic [3:0]  azmux_o;
  logic [1:0]  sw_pc_ctl_o;
  logic        busy_o, sample_valid_o;
  logic [1:0]  sample_slot_o;
  logic [15:0] sample_count_o;
  logic [2:0]  status_o;

  acq_scheduler #(.N_SLOTS(4), .CNT_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .n_slots_i(n_slots_i), .cfg_we_i(cfg_we_i),
    .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .p_clk_count_precharge_i(p_clk_count_precharge_i), .timeout_i(timeout_i),
    .adc_measure_valid_i(adc_measure_valid_i), .adc_reset_no(adc_reset_no),
    .azmux_o(azmux_o), .sw_pc_ctl_o(sw_pc_ctl_o), .busy_o(busy_o),
    .sample_valid_o(sample_valid_o), .sample_slot_o(sample_slot_o),
    .sample_count_o(sample_count_o), .status_o(status_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  slot;
    logic [15:0] count;
    logic [3:0]  az;
    logic [1:0]  pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   adc_delay = -1;   // edges after adc_reset_no rises at which valid is sampled; -1 = never
  int   adc_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] s, input logic [15:0] c, input logic [3:0] a,
                      input logic [1:0] p);
    exp_t e;
    e.slot = s; e.count = c; e.az = a; e.pc = p;
    sb.push_back(e);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [5:0] data);
    cfg_addr_i = addr;
    cfg_data_i = data;
    cfg_we_i   = 1'b1;
    tick();
    cfg_we_i   = 1'b0;
  endtask

  task automatic setup(input logic [2:0] n, input logic cont, input int p, input int t,
                       input int d);
    n_slots_i               = n;
    continuous_i            = cont;
    p_clk_count_precharge_i = 24'(p);
    timeout_i               = 24'(t);
    adc_delay               = d;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    check(name, busy_o, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Behavioural ADC: answers a fixed number of edges after it is released from reset.
  initial begin
    adc_measure_valid_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (adc_reset_no) begin
        adc_measure_valid_i = (adc_delay > 0 && adc_cnt == adc_delay - 1);
        adc_cnt++;
      end else begin
        adc_measure_valid_i = 1'b0;
        adc_cnt = 0;
      end
    end
  end

  // Monitor: every completed sample must match the head of the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_n && sample_valid_o) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_sample: got slot %0d count %0d, expected no sample (t=%0t)",
                   sample_slot_o, sample_count_o, $time);
        end else begin
          mon_e = sb.pop_front();
          check("sample_slot", sample_slot_o, mon_e.slot);
          check("sample_count", sample_count_o, mon_e.count);
          check("sample_azmux", azmux_o, mon_e.az);
          check("sample_pc", sw_pc_ctl_o, mon_e.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; cfg_we_i = 1'b0;
    cfg_addr_i = '0; cfg_data_i = '0;
    setup(3'd1, 1'b0, 0, 100, -1);
    tick();
    tick();
    check("rst_busy", busy_o, 1'b0);
    check("rst_status", status_o, 3'b000);
    check("rst_adc_reset", adc_reset_no, 1'b0);
    reset_n = 1'b1;
    tick();

    // Mid-run reset with a populated table.
    cfg_write(2'd0, {4'h3, 2'b01});
    cfg_write(2'd1, {4'h7, 2'b00});
    setup(3'd2, 1'b0, 3, 100, 5);
    start_run();
    repeat (6) tick();
    check("prerst_azmux", azmux_o, 4'h3);
    reset_n = 1'b0;
    tick();
    tick();
    check("midrst_adc_reset", adc_reset_no, 1'b0);
    check("midrst_azmux", azmux_o, 4'h0);
    check("midrst_pc", sw_pc_ctl_o, 2'b00);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_valid", sample_valid_o, 1'b0);
    check("midrst_slot", sample_slot_o, 2'd0);
    check("midrst_count", sample_count_o, 16'd0);
    check("midrst_status", status_o, 3'b000);
    reset_n = 1'b1;
    tick();

    // Table must have been cleared: slot 0 measures with azmux 0 / pc 00.
    setup(3'd1, 1'b0, 0, 100, 2);
    push(2'd0, 16'd1, 4'h0, 2'b00);
    start_run();
    wait_idle("readback_done", 200);
    check("readback_status", status_o, 3'b001);

    // Single-shot, two slots, P=3, ADC answers 5 edges after release.
    cfg_write(2'd0, {4'h3, 2'b01});
    cfg_write(2'd1, {4'h7, 2'b00});
    setup(3'd2, 1'b0, 3, 100, 5);
    push(2'd0, 16'd1, 4'h3, 2'b01);
    push(2'd1, 16'd2, 4'h7, 2'b00);
    start_run();
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1)  check("ss_busy", busy_o, 1'b1);
      if (k == 3)  check("ss_azmux_e3", azmux_o, 4'h0);
      if (k == 4)  check("ss_azmux_e4", azmux_o, 4'h3);
      if (k == 7)  check("ss_pc_e7", sw_pc_ctl_o, 2'b00);
      if (k == 8)  check("ss_pc_e8", sw_pc_ctl_o, 2'b01);
      if (k == 11) check("ss_adc_e11", adc_reset_no, 1'b0);
      if (k == 12) check("ss_adc_e12", adc_reset_no, 1'b1);
    end
    wait_idle("ss_done", 300);
    check("ss_count", sample_count_o, 16'd2);
    check("ss_status", status_o, 3'b001);
    check("ss_adc_idle", adc_reset_no, 1'b0);

    // Continuous, three slots, stop during slot 1 of the second pass; table write while busy.
    cfg_write(2'd2, {4'hA, 2'b10});
    setup(3'd3, 1'b1, 1, 100, 3);
    push(2'd0, 16'd1, 4'h3, 2'b01);
    push(2'd1, 16'd2, 4'h7, 2'b00);
    push(2'd2, 16'd3, 4'hA, 2'b10);
    push(2'd0, 16'd4, 4'h3, 2'b01);
    push(2'd1, 16'd5, 4'h7, 2'b00);
    start_run();
    cfg_write(2'd0, {4'hF, 2'b11});
    begin
      int n = 0;
      while (sample_count_o != 16'd4 && n < 400) begin
        tick();
        n++;
      end
      check("cont_reach4", sample_count_o, 16'd4);
    end
    tick();
    tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    wait_idle("cont_done", 300);
    continuous_i = 1'b0;
    check("cont_count", sample_count_o, 16'd5);
    check("cont_status", status_o, 3'b001);

    // P=0: one-cycle phases; slot 0 must still hold {3,01}.
    setup(3'd1, 1'b0, 0, 100, 2);
    push(2'd0, 16'd1, 4'h3, 2'b01);
    start_run();
    tick();
    tick();
    check("p0_adc_e2", adc_reset_no, 1'b0);
    tick();
    check("p0_adc_e3", adc_reset_no, 1'b1);
    wait_idle("p0_done", 100);
    check("p0_count", sample_count_o, 16'd1);

    // start_i together with stop_i in IDLE: no run.
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    repeat (4) tick();
    check("startstop_busy", busy_o, 1'b0);
    check("startstop_adc", adc_reset_no, 1'b0);
    check("startstop_count", sample_count_o, 16'd1);

    // Timeout: T=10, ADC silent; release at edge 3, timeout at edge 14.
    do_reset();
    setup(3'd1, 1'b0, 0, 10, -1);
    start_run();
    repeat (3) tick();
    check("to_adc_rise", adc_reset_no, 1'b1);
    repeat (10) tick();
    check("to_adc_e13", adc_reset_no, 1'b1);
    check("to_busy_e13", busy_o, 1'b1);
    tick();
    check("to_adc_e14", adc_reset_no, 1'b0);
    check("to_status", status_o, 3'b100);
    check("to_busy", busy_o, 1'b0);
    check("to_count", sample_count_o, 16'd0);

    // Valid on the same edge the timeout expires: the sample wins.
    setup(3'd1, 1'b0, 0, 10, 11);
    push(2'd0, 16'd1, 4'h0, 2'b00);
    start_run();
    wait_idle("vw_done", 100);
    check("vw_count", sample_count_o, 16'd1);
    check("vw_status", status_o, 3'b001);

    repeat (3) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acq_scheduler.md
Name: acq_scheduler

Overview:
Programmable sequencer that owns the AZ mux, the precharge switch and the ADC reset/valid handshake. It steps through a table of up to 4 sample slots; each slot holds an azmux code and a precharge-switch code. Per slot it runs: precharge to boot, azmux select, precharge to signal, ADC measure. It runs single-shot or continuous, with a measurement timeout, and sits between the register bank and the ADC/analog switch pins.

Parameters:
N_SLOTS, 4, number of table slots (power of 2)
CNT_W, 24, width of dwell and timeout counters

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
start_i  in  1  start run (sampled in IDLE only)
stop_i  in  1  request stop after current sample
continuous_i  in  1  1 = wrap slots forever, 0 = one pass
n_slots_i  in  3  active slots, 1..N_SLOTS (0 treated as 1)
cfg_we_i  in  1  table write strobe
cfg_addr_i  in  2  table slot index
cfg_data_i  in  6  {azmux[3:0], pc[1:0]}
p_clk_count_precharge_i  in  CNT_W  phase dwell P
timeout_i  in  CNT_W  max measure cycles T
adc_measure_valid_i  in  1  ADC conversion complete
adc_reset_no  out  1  0 = ADC held in reset
azmux_o  out  4  AZ mux select
sw_pc_ctl_o  out  2  precharge switch control
busy_o  out  1  run in progress
sample_valid_o  out  1  1-cycle pulse per completed sample
sample_slot_o  out  2  slot of last completed sample
sample_count_o  out  16  completed samples since start, wraps at 65535->0
status_o  out  3  {timeout_err, running, sample_seen}

Behaviour:
- Reset is synchronous and active-low on reset_n. All outputs go to 0, state goes to IDLE, and all table entries go to 0. Reset overrides everything, mid-run included.
- Table writes are accepted only when busy_o=0; writes while busy are ignored. The slot contents used are latched on entry to PC_BOOT.
- Dwell rule: on state entry the down-counter loads P. The state exits in the cycle where the counter reaches 0, so it lasts P+1 cycles. P=0 gives 1 cycle.
- IDLE:
  - adc_reset_no=0, busy_o=0.
  - start_i=1 and stop_i=0: clear sample_count_o, clear status_o[2], slot=0, set busy_o and status_o[1], go to PC_BOOT.
  - start_i and stop_i together: stay in IDLE.
- PC_BOOT: sw_pc_ctl_o=00, latch slot entry, dwell, then go to AZMUX.
- AZMUX: azmux_o=slot.azmux, dwell, then go to PC_SIG.
- PC_SIG: sw_pc_ctl_o=slot.pc, dwell, then go to MEASURE.
- MEASURE:
  - Set adc_reset_no=1 and load the timeout counter with T.
  - adc_measure_valid_i=1:
    - adc_reset_no=0 and sample_valid_o pulses.
    - sample_slot_o=slot, sample_count_o +1, status_o[0]=1.
    - Then go to NEXT.
  - Counter reaches 0 with no valid: adc_reset_no=0, status_o[2]=1, status_o[1]=0, busy_o=0, go to IDLE.
  - Valid and timeout in the same cycle: valid wins.
- NEXT (1 cycle), checked in this order:
  - A stop request is latched (stop_i seen at any cycle since start): go to IDLE.
  - slot = n_slots-1 and continuous_i=0: go to IDLE.
  - Otherwise slot = (slot+1) mod n_slots, then go to PC_BOOT.
  - Every exit to IDLE clears status_o[1] and busy_o.
- azmux_o and sw_pc_ctl_o hold their last values in IDLE.
- Latency: adc_reset_no rises exactly 3(P+1) clocks after the edge that samples start_i.

Test Plan:
- Reset: reset_n=0 for 2 cycles with prior nonzero state -> all outputs 0, table reads back as 0 on the next run.
- Single-shot run:
  - Setup: table slot0={S3,01}, slot1={S7,00}; n_slots=2, continuous=0, P=3, T=100; ADC returns valid 5 cycles after adc_reset_no rises.
  - azmux_o changes at edge start+4 and sw_pc_ctl_o=01 at edge start+8.
  - adc_reset_no rises at edge start+12.
  - Exactly two sample_valid_o pulses, with slots 0 then 1; sample_count_o=2; then IDLE, busy_o=0, status_o=3'b001.
- P=0: each dwell phase lasts 1 cycle -> adc_reset_no rises 3 cycles after start.
- Continuous mode with n_slots=3: slots run 0,1,2,0,1. stop_i pulses during slot 1 of the second pass -> that sample completes, then IDLE; sample_count_o=5.
- Timeout: T=10, ADC never valid -> 11 cycles after adc_reset_no rises, adc_reset_no=0, status_o=3'b100, busy_o=0; no sample_valid_o.
- Edge cases:
  - Valid in the same cycle the timeout counter hits 0 -> sample counted, no error.
  - cfg write while busy -> table unchanged.
  - start_i and stop_i together in IDLE -> no run.
